// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared types for the retire-trace writer.
//   trace_rec_t   - one retire record (pc, instr, regfile write, optional cycle)
//   RECORD_W      - packed width of trace_rec_t (102, or 134 with timestamps)
//   trace_state_t - writer FSM states
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN adds a 32-bit cycle field.
package commit_trace_pkg;

    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_rec_t;

    localparam int RECORD_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with a registered head.
//   clk, rst   - clock, async active-high reset (flushes pointers and head)
//   push, din  - write request/data; accepted when not full, or full with a pop
//   pop        - consumer takes the head; ignored while head_valid=0
//   dout       - registered head record, holds its value while empty
//   head_valid - dout holds a valid entry
//   full/empty - pointer-derived occupancy flags
// An entry written at edge N reaches the head register at edge N+1.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 102
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             head_valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, rd_ptr_nxt, count;
    logic             do_push, do_pop, head_nxt;

    // Extra MSB on each pointer separates full from empty when the indexes match.
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop & head_valid;
    assign do_push    = push & (~full | do_pop);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);

    // Only entries already in memory before this edge may reach the head, which
    // gives every record exactly one cycle of write latency.
    assign head_nxt = (count != (AW+1)'(do_pop));

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            dout       <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_ptr_nxt;
            head_valid <= head_nxt;
            if (head_nxt) dout <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/commit_trace_writer.sv
// commit_trace_writer: captures one record per retired instruction, buffers it
// in trace_fifo and drains it over a valid/ready port until a record limit.
//   clk, rst            - core clock, async active-high reset (stream restart)
//   enable              - level-sensitive capture enable
//   ret_*               - retire bus from writeback (pc, instr, regfile write)
//   out_valid/out_ready - record handshake; out_* is the head record
//   out_waddr/out_wdata - zero whenever out_we=0
//   rec_count           - records accepted into the FIFO (saturating)
//   drop_count          - records lost to a full FIFO (saturating)
//   done                - MAX_RECORDS accepted and FIFO drained (sticky)
// Optional feature macro: COMMIT_TRACE_TIMESTAMP_EN adds out_cycle, the
// free-running cycle count sampled at the retire edge.
module commit_trace_writer #(
    parameter int DEPTH       = 8,
    parameter int MAX_RECORDS = 5000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ret_valid,
    input  logic [31:0]      ret_pc,
    input  logic [31:0]      ret_instr,
    input  logic             ret_we,
    input  logic [4:0]       ret_waddr,
    input  logic [31:0]      ret_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic             out_we,
    output logic [4:0]       out_waddr,
    output logic [31:0]      out_wdata,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    output logic [31:0]      out_cycle,
`endif
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             done
);

    import commit_trace_pkg::*;

    localparam logic [31:0]      MAX_U   = 32'(MAX_RECORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trace_state_t        state, state_nxt;
    trace_rec_t          wr_rec, rd_rec;
    logic [RECORD_W-1:0] rd_bits;
    logic                fifo_full, fifo_empty, head_valid;
    logic                cap_en, limit_hit, capture, pop, accepted;

    // MAX_RECORDS=0 disables the limit.
    assign limit_hit = (MAX_U != 32'd0) && (32'(rec_count) >= MAX_U);
    assign capture   = cap_en & ret_valid & (ret_pc != 32'd0) & ~limit_hit;
    assign pop       = head_valid & out_ready;
    // Mirrors the FIFO acceptance rule: a pop in the same cycle frees a slot.
    assign accepted  = capture & (~fifo_full | pop);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (enable) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (limit_hit)    state_nxt = ST_DRAIN;
                else if (!enable) state_nxt = ST_IDLE;
            end
            ST_DRAIN:   if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_en = (state == ST_CAPTURE);
        done   = (state == ST_DONE);
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_count  <= '0;
            drop_count <= '0;
        end else begin
            if (accepted && rec_count != CNT_MAX)
                rec_count <= rec_count + 1'b1;
            if (capture && !accepted && drop_count != CNT_MAX)
                drop_count <= drop_count + 1'b1;
        end
    end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_cnt <= 32'd0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    // Records are sanitised on entry: a write to x0 is stored as no write, and
    // rd/wdata are zeroed whenever there is no write.
    always_comb begin
        wr_rec       = '0;
        wr_rec.pc    = ret_pc;
        wr_rec.instr = ret_instr;
        wr_rec.we    = ret_we && (ret_waddr != 5'd0);
        if (wr_rec.we) begin
            wr_rec.waddr = ret_waddr;
            wr_rec.wdata = ret_wdata;
        end
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        wr_rec.cycle = cycle_cnt;
`endif
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RECORD_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .din        (wr_rec),
        .pop        (out_ready),
        .dout       (rd_bits),
        .head_valid (head_valid),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rd_rec    = rd_bits;
    assign out_valid = head_valid;
    assign out_pc    = rd_rec.pc;
    assign out_instr = rd_rec.instr;
    assign out_we    = rd_rec.we;
    assign out_waddr = rd_rec.waddr;
    assign out_wdata = rd_rec.wdata;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    assign out_cycle = rd_rec.cycle;
`endif

endmodule

// File: doc/commit_trace_writer.md
Name: commit_trace_writer

Overview:
- Writer side of the retire-trace interface between the pipelined CPU and its consumer (debug bridge or simulation monitor).
- Sits after writeback and captures one record per retired instruction: pc, instr, and optional regfile write (rd, wdata).
- Buffers records in a FIFO, drains them over a valid/ready port, and stops after a programmed record limit.
- Replaces software-side pc-change polling with an exact hardware commit stream.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- MAX_RECORDS, 5000, records accepted before the block goes DONE; 0 means unlimited.
- CNT_W, 16, width of the record and drop counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  trace capture enable; level-sensitive.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  32  pc of the retiring instruction.
- ret_instr  in  32  instruction word.
- ret_we  in  1  retiring instruction writes the regfile.
- ret_waddr  in  5  destination register.
- ret_wdata  in  32  write data.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_pc  out  32  record pc.
- out_instr  out  32  record instr.
- out_we  out  1  record write flag.
- out_waddr  out  5  record rd; forced to 0 when out_we=0.
- out_wdata  out  32  record wdata; forced to 0 when out_we=0.
- rec_count  out  CNT_W  records accepted into the FIFO; saturates.
- drop_count  out  CNT_W  records lost to a full FIFO; saturates.
- done  out  1  MAX_RECORDS reached and FIFO drained.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; out_valid=0; all out_* data=0.
  - rec_count=0, drop_count=0, done=0; state=IDLE.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE -> CAPTURE when enable=1.
  - CAPTURE -> IDLE when enable=0; FIFO contents are kept and continue draining.
  - CAPTURE -> DRAIN when rec_count reaches MAX_RECORDS (MAX_RECORDS != 0).
  - DRAIN -> DONE when FIFO is empty.
  - DONE is sticky until reset; done=1 only in DONE.
- Capture condition: state=CAPTURE, ret_valid=1, ret_pc != 0. Records with pc 0 are never traced.
- ret_we=1 with ret_waddr=0 is recorded with out_we=0.
- Write latency: a record captured at edge N is visible at the output (out_valid=1) after edge N+1, i.e. one registered stage.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Full FIFO with capture asserted: the record is dropped, drop_count++, and rec_count is unchanged.
- Simultaneous push and pop while full: the pop frees a slot, the push is accepted, and there is no drop.
- Empty FIFO: out_valid=0 and out_* hold their last values.
- Pointers are log2(DEPTH)+1 bits wide, wrap naturally, and the MSB distinguishes full from empty.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-stream: the FIFO is flushed immediately and partial records are lost. The consumer must treat rst as a stream restart.
- The record that makes rec_count equal MAX_RECORDS is accepted. Later retires are ignored and not counted as drops.

Optional Feature:
- Macro: COMMIT_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds output out_cycle (32 bits), the free-running cycle count since reset captured at the retire edge.
  - The counter wraps at 2^32.
  - Each FIFO entry widens by 32 bits.
- Undefined: no out_cycle port and no cycle counter; the FIFO width is 102 bits.

Decomposition:
- Shared package commit_trace_pkg:
  - Record struct typedef (pc, instr, we, waddr, wdata, optional cycle).
  - RECORD_W constant.
  - FSM state enum.
- Sub-module trace_fifo: a parameterized synchronous FIFO (DEPTH, WIDTH) providing full, empty, push, pop, and a registered head.

Test Plan:
- Reset and enable, then 3 retires (pc 0x4, 0x8, 0xC), out_ready=1 -> 3 records in order one cycle later; rec_count=3.
- Retire with pc 0x0, then pc 0x10 with we=1, waddr=28, wdata=0xDEADBEEF -> only the 0x10 record appears, with out_waddr=28 and out_wdata=0xDEADBEEF.
- out_ready=0 with DEPTH=8 and 10 retires -> 8 buffered, drop_count=2, out_* stable; then out_ready=1 -> 8 records drain.
- MAX_RECORDS=4, 6 retires -> exactly 4 records, drop_count=0; done=1 after the last transfer.
- Full FIFO with simultaneous push and pop -> no drop; order preserved.
- Assert rst mid-drain with 5 entries pending -> out_valid=0 and counters=0 immediately; capture resumes cleanly after release.
